// File: rtl/serial_pattern_tx_pkg.sv
// Shared FSM state encoding for serial_pattern_tx.
// ST_PARITY only exists when SERIAL_TX_PARITY_EN is defined.
package serial_pattern_tx_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY = 2'd3,
`endif
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Load/ready word handshake plus serial x stream of serial_pattern_tx.
interface serial_pattern_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             x_out;
    logic             x_valid;
    logic             done;

    modport master (
        output data_in, load,
        input  ready, x_out, x_valid, done
    );

    modport slave (
        input  data_in, load,
        output ready, x_out, x_valid, done
    );
endinterface

// File: rtl/serial_pattern_tx_shift_reg.sv
// Loadable WIDTH-bit shift register; head is the next bit to transmit.
module tx_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             head
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= data_in;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                q <= {q[WIDTH-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[WIDTH-1:1]};
            end
        end
    end

    assign head = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial pattern transmitter feeding the detector's x input.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after each word.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    serial_pattern_tx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_bit;
    logic             head;
    logic             ready;
    logic             x_valid;
    logic             x_out;
    logic             done;

    assign accept   = (state == ST_IDLE) && bus.load;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    tx_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load_en  (accept),
        .shift_en (state == ST_SHIFT),
        .data_in  (bus.data_in),
        .head     (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the index of the bit currently on x_out while in SHIFT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == ST_SHIFT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^bus.data_in;
        end
    end
`endif

    // Outputs decode only registered state, so inputs never reach them combinationally
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        x_valid   = 1'b0;
        x_out     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.load) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                x_valid = 1'b1;
                x_out   = head;
                if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                x_valid   = 1'b1;
                x_out     = parity_q;
                state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.ready   = ready;
    assign bus.x_valid = x_valid;
    assign bus.x_out   = x_out;
    assign bus.done    = done;

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Parallel-to-serial pattern transmitter that produces the serial input stream `x` consumed by the team's clocked sequence-detector FSMs (the JK/D flip-flop Mealy machines).
- Accepts a WIDTH-bit word through a load/ready handshake.
- Shifts the word out one bit per clock with a qualifying valid strobe.
- Signals completion with a one-cycle done pulse.
- Used as the stimulus/driver end of the detector's serial input in lab top-levels and benches.

Parameters:
WIDTH, 8, number of data bits per word (legal range 2..16)
MSB_FIRST, 1, 1 = transmit data_in[WIDTH-1] first; 0 = transmit data_in[0] first

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, asynchronous, active-low
data_in  input  WIDTH  word to transmit, sampled only on accepted load
load  input  1  request to transmit data_in
ready  output  1  high when block can accept load (IDLE only)
x_out  output  1  serial data bit; drives detector input x
x_valid  output  1  high while x_out carries a transmitted bit
done  output  1  one-cycle pulse after last bit

Behaviour:
- Reset (rst low, any time, async): state=IDLE, ready=1, x_out=0, x_valid=0, done=0, shift register=0, bit counter=0. Reset mid-word aborts immediately; no partial done.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SHIFT, DONE (plus PARITY when the optional feature is compiled in). State encoding is binary.
- IDLE: ready=1, x_valid=0, x_out=0, done=0.
  - On posedge with load=1: capture data_in into the shift register, clear the bit counter, go to SHIFT.
  - The first bit appears on x_out in the clock period immediately after the accepting edge (latency 1).
- SHIFT: x_valid=1, ready=0, and x_out = current head bit.
  - Order is MSB_FIRST ? MSB-to-LSB : LSB-to-MSB.
  - Each edge advances one bit and increments the counter.
  - The counter is $clog2(WIDTH+1) bits wide; no wrap occurs within a word.
  - After exactly WIDTH valid periods, go to DONE.
- DONE: exactly one period. done=1, x_valid=0, x_out=0, ready=0. Next edge goes to IDLE.
- A word occupies WIDTH+1 periods; ready returns in period WIDTH+2 after acceptance.
- Back-to-back: a load asserted during DONE is ignored. A load held high into IDLE is accepted on the first IDLE edge.
- load while ready=0: ignored, no effect. data_in changes after acceptance: no effect on the word in flight.
- x_out is forced to 0 whenever x_valid=0.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one period with x_valid=1 and x_out = even parity of the captured word (XOR of all WIDTH bits).
  - It then goes to DONE.
  - A word occupies WIDTH+2 periods.
- Undefined:
  - PARITY state and parity register are absent.
  - SHIFT goes directly to DONE.

Decomposition:
- Shared package/include (serial_tx_defs): state encodings ST_IDLE, ST_SHIFT, ST_PARITY, ST_DONE as localparams, plus the state width constant.
- One natural sub-module, tx_shift_reg: WIDTH-bit loadable shift register with direction select. It exposes head bit and load/shift enables.
- The FSM, counter and parity logic stay in serial_pattern_tx.

Test Plan:
1. Reset: rst low mid-SHIFT at any cycle -> same cycle x_valid=0, x_out=0, done=0, ready=1. After release, the next load transmits a clean word.
2. WIDTH=8, MSB_FIRST=1, data_in=8'hA5, load one cycle -> x_out 1,0,1,0,0,1,0,1 over 8 consecutive x_valid periods. Then done=1 for one period, then ready=1.
3. WIDTH=8, MSB_FIRST=0, data_in=8'h0D -> x_out 1,0,1,1,0,0,0,0. Connected to the detector's x input, the detector's y stream must match its golden model for that sequence.
4. Load asserted while busy, with data_in changed to 8'hFF mid-word -> in-flight word unchanged, no second word started. Load held high continuously -> words start every 10 periods (WIDTH+2).
5. SERIAL_TX_PARITY_EN defined, data_in=8'hA5 -> 8 data bits then parity bit 0 with x_valid=1, done in period 10. With data_in=8'h07 -> parity bit 1.
6. WIDTH=2, data_in=2'b10 -> x_out 1,0 then done. Verifies the counter boundary at minimum width.
